// File: rtl/mips_multicycle.sv
// mips_multicycle: FSM-sequenced MIPS subset core on one unified req/ready memory.
// Ports: clk, reset; mem_req/we/addr/wdata/rdata/ready; wb_en/pc/reg/data trace; trap.
module mips_multicycle #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter bit          TRACE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        wb_en,
  output logic [31:0] wb_pc,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        trap
);
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] grf_q [32];

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, wdst;
  logic        is_r, legal;
  logic        i_nop, i_addu, i_subu, i_jr, i_ori;
  logic        i_lui, i_lw, i_sw, i_beq, i_jal;
  logic [31:0] imm_ext, ea, alu_res, wval;
  logic        grf_we;

  assign op = ir_q[31:26];
  assign rs = ir_q[25:21];
  assign rt = ir_q[20:16];
  assign rd = ir_q[15:11];
  assign fn = ir_q[5:0];

  // Decode, immediate forms and write-back selection.
  always_comb begin
    is_r   = op == 6'h00;
    i_nop  = ir_q == 32'h0;
    i_addu = is_r && fn == 6'h21;
    i_subu = is_r && fn == 6'h23;
    i_jr   = is_r && fn == 6'h08;
    i_ori  = op == 6'h0d;
    i_lui  = op == 6'h0f;
    i_lw   = op == 6'h23;
    i_sw   = op == 6'h2b;
    i_beq  = op == 6'h04;
    i_jal  = op == 6'h03;
    legal  = i_nop | i_addu | i_subu | i_jr | i_ori
           | i_lui | i_lw | i_sw | i_beq | i_jal;
    imm_ext = {{16{ir_q[15]}}, ir_q[15:0]};
    if (i_ori) imm_ext = {16'h0, ir_q[15:0]};
    if (i_lui) imm_ext = {ir_q[15:0], 16'h0};
    wdst = i_jal ? 5'd31 : (is_r ? rd : rt);
    wval = i_lw ? mdr_q : alu_q;
    grf_we = state_q == S_WB && wdst != 5'd0;
  end

  always_comb begin
    ea      = a_q + imm_q;
    alu_res = '0;
    unique case (1'b1)
      i_addu:     alu_res = a_q + b_q;
      i_subu:     alu_res = a_q - b_q;
      i_ori:      alu_res = a_q | imm_q;
      i_lui:      alu_res = imm_q;
      i_lw, i_sw: alu_res = ea;
      // pc_q already holds the link address (instruction PC + 4).
      i_jal:      alu_res = pc_q;
      default:    alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RESET;
      ipc_q   <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      for (int i = 0; i < 32; i++) grf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      if (grf_we) grf_q[wdst] <= wval;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    unique case (state_q)
      S_FETCH: if (mem_ready) begin
        ir_d    = mem_rdata;
        ipc_d   = pc_q;
        pc_d    = pc_q + 32'd4;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // grf_q[0] is never written, so $0 reads as zero.
        a_d     = grf_q[rs];
        b_d     = grf_q[rt];
        imm_d   = imm_ext;
        state_d = legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        alu_d = alu_res;
        unique case (1'b1)
          i_lw, i_sw:
            state_d = ea[1:0] != 2'b00 ? S_TRAP : S_MEM;
          i_beq: begin
            if (a_q == b_q) pc_d = pc_q + {imm_q[29:0], 2'b00};
            state_d = S_FETCH;
          end
          i_jr: begin
            pc_d    = a_q;
            state_d = S_FETCH;
          end
          i_jal: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            state_d = S_WB;
          end
          i_nop:   state_d = S_FETCH;
          default: state_d = S_WB;
        endcase
      end
      S_MEM: if (mem_ready) begin
        mdr_d   = mem_rdata;
        state_d = i_sw ? S_FETCH : S_WB;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_TRAP;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wb_en     = 1'b0;
    wb_pc     = '0;
    wb_reg    = '0;
    wb_data   = '0;
    trap      = state_q == S_TRAP;
    unique case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_we    = i_sw;
        mem_addr  = alu_q;
        mem_wdata = i_sw ? b_q : '0;
      end
      S_WB: if (TRACE_EN) begin
        wb_en   = 1'b1;
        wb_pc   = ipc_q;
        wb_reg  = wdst;
        wb_data = wval;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: directed and random programs on a wait-state memory,
// compared against an instruction-level reference model.
module tb_mips_multicycle;
  localparam logic [31:0] PCR = 32'h0000_3000;
  localparam logic [31:0] ILL = 32'hfc00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        wb_en, trap;
  logic [31:0] wb_pc, wb_data;
  logic [4:0]  wb_reg;

  mips_multicycle #(.PC_RESET(PCR), .TRACE_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wb_en(wb_en), .wb_pc(wb_pc),
    .wb_reg(wb_reg), .wb_data(wb_data),
    .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] data;
    int          cyc;
  } wb_t;
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } acc_t;

  bit [31:0]   mem  [4096];
  bit [31:0]   rmem [4096];
  logic [31:0] rr   [32];
  wb_t         exp_wb[$], obs_wb[$];
  acc_t        exp_acc[$], obs_acc[$];
  int          exp_trap, obs_trap, rbase;
  int          cyc, waits, wmin, wmax, left;
  bit          busy, s_waited;
  logic [31:0] s_addr, s_wdata;
  logic        s_we;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= reset ? 1 : cyc + 1;

  // Memory responder with a per-request random wait, plus trace monitor.
  always @(negedge clk) begin
    if (reset) begin
      busy = 0;
      mem_ready = 0;
    end else begin
      if (mem_ready) busy = 0;
      mem_ready = 0;
      if (mem_req) begin
        if (!busy) begin
          busy = 1; s_waited = 0;
          s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
          left = $urandom_range(wmax, wmin);
        end
        if (left == 0) begin
          if (s_waited) begin
            chk("req_addr_stable", mem_addr, s_addr);
            chk("req_we_stable", mem_we, s_we);
            chk("req_wdata_stable", mem_wdata, s_wdata);
          end
          mem_ready = 1;
          mem_rdata = mem[mem_addr[13:2]];
          if (mem_we) mem[mem_addr[13:2]] = mem_wdata;
          obs_acc.push_back('{mem_addr, mem_we,
                              (mem_we ? mem_wdata : 32'h0)});
        end else begin
          left--; waits++; s_waited = 1;
        end
      end
      if (wb_en) obs_wb.push_back('{wb_pc, wb_reg, wb_data, cyc - waits});
      if (trap && obs_trap < 0) obs_trap = cyc - waits;
    end
  end

  function automatic logic [31:0] enc_r(input int rs, rt, rd, fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, rs, rt, imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[13:2]] = w;
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = (i >= 12'hc00) ? ILL : 32'h0;
  endtask

  // Reference: timing in zero-wait cycles, from per-instruction latency.
  task automatic retire(input logic [31:0] pc, input logic [4:0] rg,
                        input logic [31:0] v, input int lat);
    rbase += lat;
    exp_wb.push_back('{pc, rg, v, rbase});
    if (rg != 0) rr[rg] = v;
  endtask

  task automatic ref_run();
    logic [31:0] pc, ins, npc, ea, sx, va, vb;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    rmem = mem;
    exp_wb.delete(); exp_acc.delete();
    exp_trap = -1; rbase = 0; pc = PCR;
    foreach (rr[i]) rr[i] = 0;
    for (int n = 0; n < 1000; n++) begin
      ins = rmem[pc[13:2]];
      exp_acc.push_back('{pc, 1'b0, 32'h0});
      op = ins[31:26]; fn = ins[5:0];
      rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      sx = {{16{ins[15]}}, ins[15:0]};
      va = rr[rs]; vb = rr[rt];
      npc = pc + 4;
      if (ins == 0) rbase += 3;
      else if (op == 0 && fn == 6'h21) retire(pc, rd, va + vb, 4);
      else if (op == 0 && fn == 6'h23) retire(pc, rd, va - vb, 4);
      else if (op == 0 && fn == 6'h08) begin rbase += 3; npc = va; end
      else if (op == 6'h0d) retire(pc, rt, va | {16'h0, ins[15:0]}, 4);
      else if (op == 6'h0f) retire(pc, rt, {ins[15:0], 16'h0}, 4);
      else if (op == 6'h23 || op == 6'h2b) begin
        ea = va + sx;
        if (ea[1:0] != 0) begin exp_trap = rbase + 4; return; end
        if (op == 6'h23) begin
          exp_acc.push_back('{ea, 1'b0, 32'h0});
          retire(pc, rt, rmem[ea[13:2]], 5);
        end else begin
          exp_acc.push_back('{ea, 1'b1, vb});
          rmem[ea[13:2]] = vb;
          rbase += 4;
        end
      end
      else if (op == 6'h04) begin
        rbase += 3;
        if (va == vb) npc = pc + 4 + (sx << 2);
      end
      else if (op == 6'h03) begin
        retire(pc, 5'd31, pc + 4, 4);
        npc = {npc[31:28], ins[25:0], 2'b00};
      end
      else begin exp_trap = rbase + 3; return; end
      pc = npc;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1;
    @(posedge clk); #2;
    obs_wb.delete(); obs_acc.delete();
    obs_trap = -1; waits = 0;
    reset = 0;
  endtask

  task automatic run_prog(input string nm, input int lo, input int hi);
    bit bad;
    ref_run();
    wmin = lo; wmax = hi;
    do_reset();
    @(negedge clk);
    chk({nm, "/c1_req"}, mem_req, 1);
    chk({nm, "/c1_addr"}, mem_addr, PCR);
    chk({nm, "/c1_trap"}, trap, 0);
    chk({nm, "/c1_wb_en"}, wb_en, 0);
    for (int i = 0; i < 3000 && !trap; i++) @(negedge clk);
    chk({nm, "/trapped"}, trap, 1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req || wb_en || !trap) bad = 1;
    end
    chk({nm, "/trap_quiet"}, bad, 0);
    chk({nm, "/trap_cyc"}, obs_trap, exp_trap);
    chk({nm, "/wb_n"}, obs_wb.size(), exp_wb.size());
    for (int i = 0; i < obs_wb.size() && i < exp_wb.size(); i++) begin
      chk({nm, "/wb_pc"}, obs_wb[i].pc, exp_wb[i].pc);
      chk({nm, "/wb_reg"}, obs_wb[i].rg, exp_wb[i].rg);
      chk({nm, "/wb_data"}, obs_wb[i].data, exp_wb[i].data);
      chk({nm, "/wb_cyc"}, obs_wb[i].cyc, exp_wb[i].cyc);
    end
    chk({nm, "/acc_n"}, obs_acc.size(), exp_acc.size());
    for (int i = 0; i < obs_acc.size() && i < exp_acc.size(); i++) begin
      chk({nm, "/acc_addr"}, obs_acc[i].addr, exp_acc[i].addr);
      chk({nm, "/acc_we"}, obs_acc[i].we, exp_acc[i].we);
      chk({nm, "/acc_wdata"}, obs_acc[i].wdata, exp_acc[i].wdata);
    end
  endtask

  task automatic load_a();
    clear_mem();
    put(32'h3000, enc_i(6'h0d, 0, 1, 16'h1234));
    put(32'h3004, enc_i(6'h0f, 0, 2, 16'hffff));
    put(32'h3008, enc_r(2, 2, 3, 6'h21));
    put(32'h300c, enc_r(0, 1, 4, 6'h23));
    put(32'h3010, 32'h0c00_0c0c);
    put(32'h3014, enc_i(6'h04, 1, 0, 5));
    put(32'h3018, enc_i(6'h0d, 0, 0, 16'h0055));
    put(32'h301c, enc_r(0, 0, 6, 6'h21));
    put(32'h3020, enc_i(6'h23, 0, 7, 2));
    put(32'h3030, enc_i(6'h2b, 0, 1, 4));
    put(32'h3034, enc_i(6'h23, 0, 5, 4));
    put(32'h3038, enc_r(31, 0, 0, 6'h08));
  endtask

  task automatic gen_prog();
    logic [31:0] w;
    int k, a, b, c;
    clear_mem();
    for (int i = 0; i < 64; i++) mem[64 + i] = $urandom;
    for (int i = 0; i < 30; i++) begin
      k = $urandom_range(0, 7);
      a = $urandom_range(0, 7);
      b = $urandom_range(0, 7);
      c = $urandom_range(0, 7);
      case (k)
        0: w = enc_r(a, b, c, 6'h21);
        1: w = enc_r(a, b, c, 6'h23);
        2: w = enc_i(6'h0d, a, b, $urandom_range(0, 65535));
        3: w = enc_i(6'h0f, 0, b, $urandom_range(0, 65535));
        4: w = enc_i(6'h23, 0, b, 256 + 4 * $urandom_range(0, 15));
        5: w = enc_i(6'h2b, 0, b, 256 + 4 * $urandom_range(0, 15));
        6: w = enc_i(6'h04, a, b, $urandom_range(0, 3));
        default: w = 32'h0;
      endcase
      mem[12'hc00 + i] = w;
    end
    k = $urandom_range(0, 2);
    mem[12'hc00 + 30] = (k == 0) ? ILL :
                        (k == 1) ? enc_i(6'h23, 0, 1, 16'h0102) :
                                   32'h0002_08c0;
  endtask

  initial begin
    bit bad;
    load_a();
    run_prog("A0", 0, 0);
    chk("A0/n_wb", obs_wb.size(), 8);
    if (obs_wb.size() == 8) begin
      chk("A0/ori_pc", obs_wb[0].pc, 32'h3000);
      chk("A0/ori_reg", obs_wb[0].rg, 1);
      chk("A0/ori_data", obs_wb[0].data, 32'h1234);
      chk("A0/ori_cyc", obs_wb[0].cyc, 4);
      chk("A0/lui", obs_wb[1].data, 32'hffff_0000);
      chk("A0/addu_wrap", obs_wb[2].data, 32'hfffe_0000);
      chk("A0/subu", obs_wb[3].data, 32'hffff_edcc);
      chk("A0/jal_reg", obs_wb[4].rg, 31);
      chk("A0/jal_link", obs_wb[4].data, 32'h3014);
      chk("A0/jal_pc", obs_wb[4].pc, 32'h3010);
      chk("A0/lw_data", obs_wb[5].data, 32'h1234);
      chk("A0/r0_reg", obs_wb[6].rg, 0);
      chk("A0/r0_read", obs_wb[7].data, 0);
    end
    chk("A0/n_acc", obs_acc.size(), 14);
    if (obs_acc.size() == 14) begin
      chk("A0/jal_tgt", obs_acc[5].addr, 32'h3030);
      chk("A0/sw_addr", obs_acc[6].addr, 32'h4);
      chk("A0/sw_data", obs_acc[6].wdata, 32'h1234);
      chk("A0/jr_tgt", obs_acc[10].addr, 32'h3014);
      chk("A0/beq_nt", obs_acc[11].addr, 32'h3018);
    end
    load_a();
    run_prog("A3", 3, 3);

    clear_mem();
    put(32'h3000, enc_i(6'h0d, 0, 1, 16'h00aa));
    put(32'h3004, ILL);
    run_prog("B", 0, 1);
    chk("B/trap_cyc", obs_trap, 7);

    for (int t = 0; t < 8; t++) begin
      gen_prog();
      run_prog($sformatf("R%0d", t), 0, t % 3);
    end

    clear_mem();
    put(32'h3000, enc_i(6'h23, 0, 5, 16'h0100));
    wmin = 6; wmax = 6;
    do_reset();
    bad = 1;
    for (int i = 0; i < 40 && bad; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h100) bad = 0;
    end
    chk("rm/mem_seen", bad, 0);
    @(posedge clk); #2 reset = 1;
    @(posedge clk); #2 reset = 0;
    @(negedge clk);
    chk("rm/req", mem_req, 1);
    chk("rm/addr", mem_addr, PCR);
    chk("rm/we", mem_we, 0);
    chk("rm/no_wb", obs_wb.size(), 0);
    chk("rm/no_data_acc", obs_acc.size(), 1);

    clear_mem();
    put(32'h3000, enc_i(6'h04, 0, 0, -1));
    wmin = 0; wmax = 0;
    do_reset();
    repeat (12) @(negedge clk);
    chk("loop/n_fetch", obs_acc.size(), 4);
    foreach (obs_acc[i]) chk("loop/addr", obs_acc[i].addr, PCR);
    chk("loop/no_wb", obs_wb.size(), 0);
    chk("loop/no_trap", trap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
